// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, decodes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and queues
// good scan codes in a small FIFO. The FIFO is read through data_out/ren.
module ps2_keyboard #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronizers and falling-edge detection
  // ---------------------------------------------------------------------
  logic clk_s1_q, clk_s1_d;
  logic clk_s2_q, clk_s2_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d;
  logic dat_s2_q, dat_s2_d;
  logic fall;
  logic bit_in;

  // Next-state of the synchronizer chain
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
  end

  // Synchronizer flops idle high, matching the PS/2 bus idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
    end
  end

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            push_req;

  // Frame decode; a falling edge takes priority over the inactivity timeout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    timer_d   = timer_q;
    push_req  = 1'b0;
    if (fall) begin
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d  = IDLE;
          push_req = bit_in & (^{shift_q, par_q});
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (timer_q == TO_LIM) begin
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      timer_q   <= timer_d;
    end
  end

  // ---------------------------------------------------------------------
  // Scan-code FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic          ovf_q, ovf_d;
  logic          nonempty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;
  logic [7:0]    head;

  // Pop is evaluated before push, so a full FIFO being read accepts the
  // incoming code; a set of overflow wins over the clear-on-read.
  always_comb begin
    nonempty = (rptr_q != wptr_q);
    full     = (rptr_q[AW] != wptr_q[AW]) && (rptr_q[AW-1:0] == wptr_q[AW-1:0]);
    pop      = ren & nonempty;
    push_ok  = push_req & (~full | pop);
    ovf_set  = push_req & full & ~pop;
    rptr_d   = pop     ? rptr_q + (AW+1)'(1) : rptr_q;
    wptr_d   = push_ok ? wptr_q + (AW+1)'(1) : wptr_q;
    if (ovf_set)  ovf_d = 1'b1;
    else if (ren) ovf_d = 1'b0;
    else          ovf_d = ovf_q;
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

  // Combinational read view of the FIFO head
  always_comb begin
    head     = nonempty ? mem_q[rptr_q[AW-1:0]] : 8'h00;
    data_out = {6'b000000, ovf_q, nonempty, head};
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: constant-vector table, hand-written corner
// sequences, and randomized frames checked against a queue-based model.
module tb_ps2_keyboard;

  localparam int HALF  = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ren;
  logic [15:0] data_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  logic       m_ovf;

  ps2_keyboard #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ren      (ren),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    bit          par_good;
    bit          stop;
    logic [15:0] exp_frame;
    logic [15:0] exp_read;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: data_out=%h expected=%h", name, data_out, exp);
    end
  endtask

  function automatic logic [15:0] model_out();
    if (mq.size() > 0) return {6'b0, m_ovf, 1'b1, mq[0]};
    return {6'b0, m_ovf, 1'b0, 8'h00};
  endfunction

  // One PS/2 bit; optionally pulses ren in the cycle the falling edge is consumed
  task automatic ps2_bit(input logic b, input bit ren_at_edge);
    ps2_data = b;
    wait_neg(HALF);
    ps2_clk = 1'b0;
    if (ren_at_edge) begin
      wait_neg(2);
      ren = 1'b1;
      wait_neg(1);
      ren = 1'b0;
      wait_neg(HALF - 3);
    end else begin
      wait_neg(HALF);
    end
    ps2_clk = 1'b1;
    wait_neg(HALF);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit par_good,
                            input bit stop, input bit ren_at_stop);
    logic p;
    p = par_good ? ~(^code) : ^code;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(stop, ren_at_stop);
    wait_neg(4);
    if (ren_at_stop) begin
      if (mq.size() > 0) void'(mq.pop_front());
      m_ovf = 1'b0;
    end
    if (par_good && stop) begin
      if (mq.size() < DEPTH) mq.push_back(code);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_read();
    ren = 1'b1;
    wait_neg(1);
    ren = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    m_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_neg(3);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    wait_neg(2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nr;
    logic [7:0] code;
    bit pg, st, rs;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 16'h011C, 16'h0000};
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[2] = '{8'h1C, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 16'h01F0, 16'h0000};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 16'h0100, 16'h0000};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 16'h01FF, 16'h0000};
    vecs[6] = '{8'hA5, 1'b0, 1'b1, 16'h0000, 16'h0000};

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ren = 1'b0;
    m_ovf = 1'b0;
    wait_neg(1);
    check("reset_held", 16'h0000);
    do_reset();
    check("reset_state", 16'h0000);

    // Table: single frames, then one read (also covers ren while empty)
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].code, vecs[i].par_good, vecs[i].stop, 1'b0);
      check($sformatf("vec%0d_frame", i), vecs[i].exp_frame);
      do_read();
      check($sformatf("vec%0d_read", i), vecs[i].exp_read);
    end

    // Nine frames into a depth-8 FIFO: overflow, then drain
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain%0d", i), (i == 0) ? 16'h0310 : 16'h0110 + 16'(i));
      do_read();
    end
    check("ovf_drained", 16'h0000);

    // Partial frame abandoned by timeout, then a clean frame
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    wait_neg(TO + 5);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("timeout_frame", 16'h01F0);
    do_read();
    check("timeout_read", 16'h0000);

    // Full FIFO, read coincides with the 9th frame's push
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b1, 1'b0);
    check("full_head", 16'h0120);
    send_frame(8'h28, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("popush%0d", i), 16'h0121 + 16'(i));
      do_read();
    end
    check("popush_empty", 16'h0000);

    // Reset in the middle of a frame
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(1'(i & 1), 1'b0);
    do_reset();
    check("midrst_state", 16'h0000);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("midrst_frame", 16'h015A);
    do_read();
    check("midrst_read", 16'h0000);

    // Randomized traffic against the queue model
    for (int it = 0; it < 40; it++) begin
      code = 8'($urandom);
      pg   = ($urandom_range(0, 3) != 0);
      st   = ($urandom_range(0, 7) != 0);
      rs   = ($urandom_range(0, 5) == 0);
      send_frame(code, pg, st, rs);
      check($sformatf("rnd%0d_frame", it), model_out());
      nr = $urandom_range(0, 1);
      for (int r = 0; r < nr; r++) begin
        do_read();
        check($sformatf("rnd%0d_read", it), model_out());
      end
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_read();
      check($sformatf("final_drain%0d", i), model_out());
    end
    check("final_empty", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter DEPTH, default 8, sets the receive FIFO depth in scan codes; it SHALL be a power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 50000, sets the clk cycles without a PS/2 falling edge after which a partial frame is abandoned.
REQ-003 Port clk  input  1  system clock; all state SHALL change only on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 Port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 Port ren  input  1  read strobe, asserted by the memory block when the CPU reads I/O address 0xF000.
REQ-008 Port data_out  output  16  combinational view of the FIFO head as {6'b0, overflow, nonempty, code[7:0]}.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer whose flops reset to 1.
REQ-010 A falling edge SHALL be detected when the previous synchronized ps2_clk is 1 and the current one is 0, using a third flop; the synchronized ps2_data SHALL be sampled in that same cycle.
REQ-011 The receiver FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-012 IDLE: on a falling edge with data 0 (start bit), go to DATA with the bit count set to 0; a falling edge with data 1 SHALL leave the FSM in IDLE.
REQ-013 DATA: each falling edge shifts in one bit LSB-first; after the 8th bit, go to PARITY.
REQ-014 PARITY: the sampled bit SHALL be stored; the frame is parity-good when the data bits plus the parity bit contain an odd number of ones; go to STOP.
REQ-015 STOP: on a falling edge, return to IDLE; the code SHALL be pushed only if the stop bit is 1 and parity is good, otherwise the frame SHALL be silently dropped.
REQ-016 A push SHALL occur on the same clk edge that consumes the stop-bit falling edge; data_out SHALL reflect it from the following cycle.
REQ-017 The timeout counter SHALL reset on every falling edge and increment in any state other than IDLE.
REQ-018 When the timeout counter reaches TIMEOUT, the FSM SHALL return to IDLE, discard the partial frame and leave the FIFO unchanged.
REQ-019 The FIFO SHALL be a circular buffer of DEPTH x 8 bits with read and write pointers one bit wider than log2(DEPTH) for full/empty detection.
REQ-020 nonempty = (pointers differ); data_out[7:0] = the head entry when nonempty, 0 when empty.
REQ-021 Pop: when ren=1 and the FIFO is nonempty, the read pointer SHALL advance at the clock edge; ren while empty SHALL have no effect.
REQ-022 Because pop and data_out are in the same cycle, the memory block's registered rdata1 SHALL capture the popped entry.
REQ-023 A push to a full FIFO SHALL be dropped and SHALL set the sticky overflow flag.
REQ-024 When pop and push coincide on a full FIFO, the pop SHALL take effect first, the push SHALL be accepted, and overflow SHALL not be set.
REQ-025 Pointers SHALL wrap modulo 2*DEPTH with no discontinuity in ordering.
REQ-026 overflow SHALL clear on any ren=1 cycle, unless an overflow is set in that same cycle, in which case set wins.
REQ-027 data_out[15:10] SHALL always read 0.

Reset
REQ-028 While rst=1: FSM to IDLE; bit count, shift register and timeout counter to 0; FIFO pointers to 0; overflow to 0; synchronizer flops to 1; data_out to 16'h0000.
REQ-029 Reset asserted mid-frame SHALL discard the frame; the first frame after rst deasserts SHALL be received normally provided its start edge comes after deassertion.
REQ-030 FIFO contents need not be cleared by reset.

Verification
REQ-031 Reset, then frame 0x1C with parity 0 and stop 1 -> data_out=16'h011C; then one ren cycle -> data_out=16'h0000 on the next cycle.
REQ-032 Frame 0x1C with parity 1 (bad), then frame 0x1C with stop bit 0 -> both dropped; data_out stays 16'h0000.
REQ-033 Nine good frames 0x10..0x18 with no reads -> data_out=16'h0310; successive reads return 0x0110..0x0117 (overflow cleared by the first read), then 0x0000.
REQ-034 Four falling edges, idle TIMEOUT+1 cycles, then full frame 0xF0 -> data_out=16'h01F0 with no corrupted entry ahead of it.
REQ-035 FIFO full (8 entries), ren asserted on the exact cycle a 9th frame's stop edge is consumed -> overflow stays 0; the 8 remaining entries end with the new code.
REQ-036 rst asserted after 6 bits of a frame, then a clean frame 0x5A -> data_out=16'h015A, with only that one entry present.
